// File: rtl/dct_vecrot.sv
// DCT post-FFT rotation: multiplies each bin X[k] by exp(-j*pi*k/(2N)) using an
// external registered twiddle ROM, with exact 48-bit output and 4-cycle latency.
`timescale 1ns/1ps
module dct_vecrot #(
  parameter int wDataIn  = 28,
  parameter int wCoef    = 18,
  parameter int wDataOut = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sink_valid,
  output logic                       sink_ready,
  input  logic [1:0]                 sink_error,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic [11:0]                fftpts_in,
  output logic [10:0]                coef_addr,
  input  logic signed [wCoef-1:0]    coef_cos,
  input  logic signed [wCoef-1:0]    coef_sin,
  output logic                       source_valid,
  input  logic                       source_ready,
  output logic [1:0]                 source_error,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic [11:0]                fftpts_out
);

  localparam int wProd = wDataIn + wCoef;

  assign sink_ready = source_ready;

  logic sink_error_unused;
  assign sink_error_unused = ^sink_error;

  // Frame-length decode: shift = log2(2048/N); unsupported lengths fall back to 0.
  logic [7:0] n_match;
  logic [2:0] shift_in;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ndec
      assign n_match[gi] = (fftpts_in == (12'd2048 >> gi));
    end
  endgenerate

  always_comb begin
    shift_in = '0;
    for (int i = 0; i < 8; i++) begin
      if (n_match[i]) shift_in = 3'(i);
    end
  end

  // Frame tracking state
  logic        active_reg;
  logic [10:0] k_cnt_reg;
  logic [2:0]  shift_reg;
  logic [11:0] n_lat_reg;

  logic        accept;
  logic [10:0] k_used;
  logic [2:0]  shift_cur;
  logic [10:0] last_k;
  logic [11:0] n_cur;

  always_comb begin
    accept    = sink_valid && (sink_sop || active_reg);
    k_used    = sink_sop ? 11'd0 : k_cnt_reg;
    shift_cur = sink_sop ? shift_in : shift_reg;
    n_cur     = sink_sop ? fftpts_in : n_lat_reg;
    last_k    = 11'h7FF >> shift_cur;
  end

  // Stage 1: input registers, ROM address issued
  logic                      s1_valid_reg, s1_sop_reg, s1_eop_reg, s1_err_reg;
  logic [11:0]               s1_n_reg;
  logic signed [wDataIn-1:0] s1_real_reg, s1_imag_reg;
  // Stage 2: data waits while the ROM read is in flight
  logic                      s2_valid_reg, s2_sop_reg, s2_eop_reg, s2_err_reg;
  logic [11:0]               s2_n_reg;
  logic signed [wDataIn-1:0] s2_real_reg, s2_imag_reg;
  // Stage 3: partial products
  logic                      s3_valid_reg, s3_sop_reg, s3_eop_reg, s3_err_reg;
  logic [11:0]               s3_n_reg;
  logic signed [wProd-1:0]   p_ac_reg, p_bs_reg, p_bc_reg, p_as_reg;

  logic signed [wProd-1:0] a_ext, b_ext, c_ext, s_ext;
  assign a_ext = {{wCoef{s2_real_reg[wDataIn-1]}}, s2_real_reg};
  assign b_ext = {{wCoef{s2_imag_reg[wDataIn-1]}}, s2_imag_reg};
  assign c_ext = {{wDataIn{coef_cos[wCoef-1]}}, coef_cos};
  assign s_ext = {{wDataIn{coef_sin[wCoef-1]}}, coef_sin};

  logic signed [wDataOut-1:0] ac_ext, bs_ext, bc_ext, as_ext;
  assign ac_ext = {{(wDataOut-wProd){p_ac_reg[wProd-1]}}, p_ac_reg};
  assign bs_ext = {{(wDataOut-wProd){p_bs_reg[wProd-1]}}, p_bs_reg};
  assign bc_ext = {{(wDataOut-wProd){p_bc_reg[wProd-1]}}, p_bc_reg};
  assign as_ext = {{(wDataOut-wProd){p_as_reg[wProd-1]}}, p_as_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg   <= 1'b0;
      k_cnt_reg    <= '0;
      shift_reg    <= '0;
      n_lat_reg    <= '0;
      coef_addr    <= '0;
      s1_valid_reg <= 1'b0;
      s1_sop_reg   <= 1'b0;
      s1_eop_reg   <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_n_reg     <= '0;
      s1_real_reg  <= '0;
      s1_imag_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_sop_reg   <= 1'b0;
      s2_eop_reg   <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_n_reg     <= '0;
      s2_real_reg  <= '0;
      s2_imag_reg  <= '0;
      s3_valid_reg <= 1'b0;
      s3_sop_reg   <= 1'b0;
      s3_eop_reg   <= 1'b0;
      s3_err_reg   <= 1'b0;
      s3_n_reg     <= '0;
      p_ac_reg     <= '0;
      p_bs_reg     <= '0;
      p_bc_reg     <= '0;
      p_as_reg     <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= 2'b00;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= 12'd2048;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        active_reg  <= !sink_eop;
        k_cnt_reg   <= (sink_eop || k_used == last_k) ? 11'd0 : k_used + 11'd1;
        if (sink_sop) begin
          shift_reg <= shift_in;
          n_lat_reg <= fftpts_in;
        end
        coef_addr   <= k_used << shift_cur;
        s1_sop_reg  <= sink_sop;
        s1_eop_reg  <= sink_eop;
        s1_err_reg  <= sink_eop && (k_used != last_k);
        s1_n_reg    <= n_cur;
        s1_real_reg <= sink_real;
        s1_imag_reg <= sink_imag;
      end

      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sop_reg  <= s1_sop_reg;
        s2_eop_reg  <= s1_eop_reg;
        s2_err_reg  <= s1_err_reg;
        s2_n_reg    <= s1_n_reg;
        s2_real_reg <= s1_real_reg;
        s2_imag_reg <= s1_imag_reg;
      end

      // coef_cos/coef_sin now hold the twiddle for the sample in stage 2
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s3_sop_reg <= s2_sop_reg;
        s3_eop_reg <= s2_eop_reg;
        s3_err_reg <= s2_err_reg;
        s3_n_reg   <= s2_n_reg;
        p_ac_reg   <= a_ext * c_ext;
        p_bs_reg   <= b_ext * s_ext;
        p_bc_reg   <= b_ext * c_ext;
        p_as_reg   <= a_ext * s_ext;
      end

      source_valid <= s3_valid_reg;
      if (s3_valid_reg) begin
        source_sop   <= s3_sop_reg;
        source_eop   <= s3_eop_reg;
        source_error <= {1'b0, s3_err_reg};
        fftpts_out   <= s3_n_reg;
        source_real  <= ac_ext + bs_ext;
        source_imag  <= bc_ext - as_ext;
      end
    end
  end

endmodule

// File: doc/dct_vecrot.md
Name: dct_vecRot

Overview:
- Post-FFT vector rotation stage of the DCT chain.
- Multiplies each FFT output bin X[k] by the twiddle exp(-j*pi*k/(2N)), where N = fftpts_in.
- Produces the full-precision 48-bit product consumed directly by dct_vecRot_scaling.
- Twiddles come from an external synchronous coefficient ROM. This block drives its address and consumes its registered outputs.

Parameters:
- wDataIn, 28: signed width of sink_real/sink_imag (FFT output).
- wCoef, 18: signed width of ROM cos/sin words, Q1.16 (65536 = 1.0).
- wDataOut, 48: signed output width. Must equal wDataIn+wCoef+2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- sink_valid  in  1  input sample valid
- sink_ready  out  1  equals source_ready (combinational)
- sink_error  in  2  ignored
- sink_sop  in  1  first bin of frame
- sink_eop  in  1  last bin of frame
- sink_real  in  wDataIn  Re X[k], signed
- sink_imag  in  wDataIn  Im X[k], signed
- fftpts_in  in  12  frame length N (16..2048, power of 2)
- coef_addr  out  11  ROM address
- coef_cos  in  wCoef  ROM cos word; 1-cycle read latency
- coef_sin  in  wCoef  ROM sin word; 1-cycle read latency
- source_valid  out  1  output valid
- source_ready  in  1  downstream ready
- source_error  out  2  2'b01 = frame length error on this eop; else 00
- source_sop  out  1  delayed sop
- source_eop  out  1  delayed eop
- source_real  out  wDataOut  Re(X[k]*W)
- source_imag  out  wDataOut  Im(X[k]*W)
- fftpts_out  out  12  N latched for the frame, delayed to align with output

Behaviour:
- Reset (rst=1, asynchronous):
  - All pipeline registers, k counter, coef_addr and all outputs go to 0.
  - fftpts_out resets to 12'd2048.
  - Asserting rst mid-frame drops in-flight samples. Output resumes only after the next valid&sop.
- Flow control:
  - sink_ready = source_ready.
  - Upstream holds sink_valid low while ready is low.
  - The pipeline advances every cycle and does not stall.
- Frame tracking:
  - Bin counter k, 11 bits.
  - On valid&sop: k_used = 0, and N is latched (N_lat).
  - Other valid cycles: k_used = k_cnt.
  - After each valid sample: k_cnt = k_used + 1, or 0 if eop.
  - Samples before the first sop (or after an eop with no new sop) are ignored: source_valid stays 0 for them.
  - A sop mid-frame restarts at k = 0 with no error.
- Frame length error:
  - If k_used reaches N_lat-1 without eop, the counter wraps to 0.
  - If eop arrives with k_used != N_lat-1, that output sample carries source_error = 2'b01.
- Address:
  - coef_addr = k_used << s, with s = log2(2048/N_lat).
  - s = 0 for 2048, 1 for 1024, 2 for 512, 3 for 256, 4 for 128, 5 for 64, 6 for 32, 7 for 16.
  - An unsupported N is treated as 2048 (s = 0). fftpts_out still passes the raw value.
  - The ROM angle is pi*addr/4096.
- Pipeline, latency 4 cycles from sink to source, all sideband delayed in lockstep:
  - Stage 1: register data, sop, eop, valid, err, N; drive coef_addr (registered).
  - Stage 2: ROM words valid; register them with the stage-1 data.
  - Stage 3: register the four products: a*c, b*s, b*c, a*s. Each is wDataIn+wCoef bits, signed.
  - Stage 4: source_real = a*c + b*s and source_imag = b*c - a*s, both sign-extended to wDataOut.
- Arithmetic:
  - Exact: no rounding, no saturation.
  - Scaling and rounding belong to dct_vecRot_scaling.
- Outputs are held when source_valid = 0. Data values in that state are don't-care but must be deterministic.

Test Plan:
- N=16, one frame, each bin real=1000, imag=0; bench ROM model. -> coef_addr sequence 0,128,...,1920. k=0 output 65536000 + j0 four cycles after the input. k=4 (addr 512, cos=60547, sin=25080) output 60547000 - j25080000. sop on k=0, eop on k=15.
- N=2048 frame, real=-(2^27), imag=2^27-1, k=0 (cos=65536, sin=0). -> real = -(2^27)*65536 and imag = (2^27-1)*65536, exact, with no wrap in 48 bits.
- Back-to-back frames N=64 then N=512 with no gap. -> addr shift changes from 5 to 2 exactly at the second sop. fftpts_out is 64 for the first 64 outputs, then 512.
- N=32 with eop asserted at k=20, then a new sop. -> the eop output has source_error=01. The next frame restarts at k=0 with error cleared.
- N=16, 20 samples with no eop. -> k wraps 15→0 and coef_addr returns to 0.
- rst pulsed asynchronously mid-frame (between clock edges). -> all outputs 0 immediately, fftpts_out=2048. Samples without sop are ignored. The next sop frame is correct.
